// File: rtl/wht_seq.sv
// Sequential N-point Walsh-Hadamard engine: stream in N samples, run one butterfly
// per cycle in place, stream out N widened coefficients. Define WHT_SEQUENCY_ORDER_EN
// to emit the coefficients in sequency (Walsh) order instead of natural Hadamard order.
module wht_seq #(
    parameter int BW   = 8,
    parameter int LOGN = 4
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BW-1:0]      in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BW+LOGN-1:0] out_data,
    output logic               out_last,
    output logic               busy
);
    localparam int N  = 1 << LOGN;
    localparam int OW = BW + LOGN;
    localparam int SW = 3;

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

    state_t          state;
    logic [LOGN-1:0] wr_cnt, rd_cnt, j_cnt;
    logic [SW-1:0]   stage_cnt;
    logic [OW-1:0]   mem [N];
    logic [LOGN-1:0] span, lo_idx, hi_idx, rd_idx;
    logic            in_fire, out_fire, last_j, last_bfly;

    assign in_fire   = (state == LOAD) && in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_j    = (j_cnt == LOGN'(N/2 - 1));
    assign last_bfly = (state == COMPUTE) && last_j && (stage_cnt == SW'(LOGN - 1));

    // lo = j with a zero spliced in at the span bit; hi sets that bit
    always_comb begin
        span   = LOGN'(1) << (SW'(LOGN - 1) - stage_cnt);
        lo_idx = ((j_cnt & ~(span - LOGN'(1))) << 1) | (j_cnt & (span - LOGN'(1)));
        hi_idx = lo_idx | span;
    end

`ifdef WHT_SEQUENCY_ORDER_EN
    function automatic logic [LOGN-1:0] seq_map(input logic [LOGN-1:0] k);
        logic [LOGN-1:0] g, r;
        g = k ^ (k >> 1);
        for (int i = 0; i < LOGN; i++) r[i] = g[LOGN-1-i];
        return r;
    endfunction
    assign rd_idx = seq_map(rd_cnt);
`else
    assign rd_idx = rd_cnt;
`endif

    assign out_data = out_valid ? mem[rd_idx] : '0;

    always_ff @(posedge wb_clk_i) begin
        if (in_fire) begin
            mem[wr_cnt] <= {{LOGN{in_data[BW-1]}}, in_data};
        end else if (state == COMPUTE) begin
            mem[lo_idx] <= mem[lo_idx] + mem[hi_idx];
            mem[hi_idx] <= mem[lo_idx] - mem[hi_idx];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state     <= LOAD;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            j_cnt     <= '0;
            stage_cnt <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (in_fire) begin
                        wr_cnt <= wr_cnt + LOGN'(1);
                        if (wr_cnt == LOGN'(N - 1)) begin
                            state    <= COMPUTE;
                            wr_cnt   <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (last_bfly) begin
                        state     <= UNLOAD;
                        j_cnt     <= '0;
                        stage_cnt <= '0;
                        out_valid <= 1'b1;
                    end else if (last_j) begin
                        j_cnt     <= '0;
                        stage_cnt <= stage_cnt + SW'(1);
                    end else begin
                        j_cnt <= j_cnt + LOGN'(1);
                    end
                end
                UNLOAD: begin
                    if (out_fire) begin
                        rd_cnt   <= rd_cnt + LOGN'(1);
                        out_last <= (rd_cnt == LOGN'(N - 2));
                        if (rd_cnt == LOGN'(N - 1)) begin
                            state     <= LOAD;
                            rd_cnt    <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_wht_seq.sv
// Directed bench for wht_seq (BW=8, LOGN=4): impulse, DC minimum, alternating row,
// backpressure with COMPUTE-time in_valid, and reset during COMPUTE.
module tb_wht_seq;
    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_data;
    logic        out_last;
    logic        busy;

    int passed = 0;
    int total  = 0;

    wht_seq #(.BW(8), .LOGN(4)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Direct-definition transform: X[k] = sum_n x[n] * (-1)^popcount(map(k) & n)
    function automatic int ref_coef(input int x[16], input int k);
        int idx, s;
        idx = k;
`ifdef WHT_SEQUENCY_ORDER_EN
        begin
            logic [3:0] g;
            g = 4'(k ^ (k >> 1));
            idx = {28'd0, g[0], g[1], g[2], g[3]};
        end
`endif
        s = 0;
        for (int n = 0; n < 16; n++)
            s += ($countones(idx & n) % 2 == 1) ? -x[n] : x[n];
        return s;
    endfunction

    task automatic send(input int x[16], input bit hold);
        for (int i = 0; i < 16; i++) begin
            int t;
            in_valid = 1'b1;
            in_data  = 8'(x[i]);
            t = 0;
            @(negedge wb_clk_i);
            while (!in_ready && t < 100) begin
                @(negedge wb_clk_i);
                t++;
            end
            if (t >= 100) check("in_timeout", t, 0);
            @(posedge wb_clk_i);
            #1;
        end
        if (hold) in_data = 8'd99;
        else in_valid = 1'b0;
    endtask

    task automatic recv(input bit bp, output int got[16]);
        int k, c;
        bit stalled;
        logic [11:0] hd;
        logic [3:0] pat;
        pat = 4'b1001;
        k = 0;
        c = 0;
        stalled = 0;
        hd = '0;
        while (k < 16 && c < 300) begin
            out_ready = bp ? pat[c % 4] : 1'b1;
            @(negedge wb_clk_i);
            if (out_valid) begin
                if (stalled) check("hold_data", $signed(out_data), $signed(hd));
                if (out_ready) begin
                    got[k] = int'($signed(out_data));
                    check($sformatf("last[%0d]", k), {31'd0, out_last}, (k == 15) ? 1 : 0);
                    k++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    hd = out_data;
                end
            end
            @(posedge wb_clk_i);
            #1;
            c++;
        end
        check("out_timeout", k, 16);
        out_ready = 1'b0;
    endtask

    task automatic check_block(input string tag, input int got[16], input int exp[16]);
        for (int k = 0; k < 16; k++)
            check($sformatf("%s[%0d]", tag, k), got[k], exp[k]);
    endtask

    initial begin
        int x[16], exp[16], got[16];
        int cnt, zc;

        // reset state
        #3;
        check("rst_in_ready", {31'd0, in_ready}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_last", {31'd0, out_last}, 0);
        check("rst_out_data", $signed(out_data), 0);
        check("rst_busy", {31'd0, busy}, 0);
        @(posedge wb_clk_i); @(posedge wb_clk_i); #1;
        wb_rst_ni = 1'b1;
        @(negedge wb_clk_i);
        check("rst_in_ready_hold", {31'd0, in_ready}, 0);
        @(negedge wb_clk_i);
        check("post_rst_in_ready", {31'd0, in_ready}, 1);
        @(posedge wb_clk_i); #1;

        // impulse
        for (int i = 0; i < 16; i++) begin x[i] = (i == 0) ? 1 : 0; exp[i] = 1; end
        send(x, 0);
        @(negedge wb_clk_i);
        check("compute_busy", {31'd0, busy}, 1);
        check("compute_in_ready", {31'd0, in_ready}, 0);
        @(posedge wb_clk_i); #1;
        recv(0, got);
        check_block("impulse", got, exp);
        @(negedge wb_clk_i);
        check("ready_after_last", {31'd0, in_ready}, 1);
        check("idle_busy", {31'd0, busy}, 0);
        @(posedge wb_clk_i); #1;

        // DC at minimum value
        for (int i = 0; i < 16; i++) begin x[i] = -128; exp[i] = 0; end
        exp[0] = -2048;
        send(x, 0);
        recv(0, got);
        check_block("dc_min", got, exp);

        // alternating row
        for (int i = 0; i < 16; i++) begin x[i] = (i % 2 == 0) ? 1 : -1; exp[i] = 0; end
`ifdef WHT_SEQUENCY_ORDER_EN
        exp[15] = 16;
`else
        exp[1] = 16;
`endif
        send(x, 0);
        recv(0, got);
        check_block("alt", got, exp);

        // backpressure; in_valid stays high through COMPUTE
        for (int i = 0; i < 16; i++) x[i] = i;
        for (int k = 0; k < 16; k++) exp[k] = ref_coef(x, k);
        send(x, 1);
        cnt = 0;
        zc = 0;
        @(negedge wb_clk_i);
        while (!out_valid && cnt < 100) begin
            if (!in_ready) zc++;
            cnt++;
            @(negedge wb_clk_i);
        end
        in_valid = 1'b0;
        check("latency", cnt, 32);
        check("in_ready_low_cycles", zc, 32);
        @(posedge wb_clk_i); #1;
        recv(1, got);
        check_block("ramp_bp", got, exp);

        // reset during COMPUTE
        for (int i = 0; i < 16; i++) begin x[i] = 7 * i - 50; end
        send(x, 0);
        repeat (9) @(posedge wb_clk_i);
        #1;
        check("mid_busy", {31'd0, busy}, 1);
        wb_rst_ni = 1'b0;
        #1;
        check("mid_rst_in_ready", {31'd0, in_ready}, 0);
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_out_valid", {31'd0, out_valid}, 0);
        check("mid_rst_out_data", $signed(out_data), 0);
        @(posedge wb_clk_i); #1;
        wb_rst_ni = 1'b1;
        @(posedge wb_clk_i); #1;
        for (int i = 0; i < 16; i++) begin x[i] = (i == 0) ? 1 : 0; exp[i] = 1; end
        send(x, 0);
        recv(0, got);
        check_block("impulse_after_rst", got, exp);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/wht_seq.md
# wht_seq

Time-multiplexed, parametrised Walsh-Hadamard transform engine: the sequential successor to the 16-point combinational transform with mux/demux front-end. It accepts N = 2^LOGN signed samples over a valid/ready stream and computes the transform in place with one shared butterfly. It then streams N widened coefficients out over a second valid/ready stream. It sits in the user project between Wishbone/LA-driven sample registers and the result readback path.

## Interface
- BW, 8: input sample width, signed two's complement.
- LOGN, 4: log2 of transform length; N = 2^LOGN, legal range 1..6.
- wb_clk_i  in  1  clock, rising edge.
- wb_rst_ni  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  sample offered.
- in_ready  out  1  engine accepts a sample this cycle.
- in_data  in  BW  signed sample.
- out_valid  out  1  coefficient offered.
- out_ready  in  1  sink accepts the coefficient.
- out_data  out  BW+LOGN  signed coefficient.
- out_last  out  1  marks coefficient N-1 of a block.
- busy  out  1  high in COMPUTE and UNLOAD.

## Operation
- Storage: N-entry buffer, each entry BW+LOGN bits. Samples are sign-extended on write. Sums are always full width, so there is no overflow or saturation.
- FSM states: LOAD, COMPUTE, UNLOAD.
- LOAD: in_ready=1. Each in_valid&in_ready writes buf[wr_cnt] and increments wr_cnt. Acceptance of sample N-1 moves the FSM to COMPUTE and clears the counters.
- COMPUTE: in_ready=0 and in_valid is ignored. One butterfly per cycle, N/2 per stage, LOGN stages, so N/2·LOGN cycles total.
  - Stage s (0..LOGN-1) uses span h = 2^(LOGN-1-s).
  - Butterfly j (0..N/2-1) pairs lo and hi = lo|h, where lo is j with a 0 inserted at bit position LOGN-1-s.
  - Update: buf[lo] ← buf[lo]+buf[hi], buf[hi] ← buf[lo]−buf[hi]. Both writes happen in the same cycle.
  - The result in buf is natural (Hadamard) order.
  - After the last butterfly, the FSM moves to UNLOAD.
- UNLOAD: out_valid=1 and out_data = buf[map(rd_cnt)].
  - Each out_valid&out_ready increments rd_cnt.
  - out_last=1 when rd_cnt=N-1.
  - The handshake on the last coefficient returns the FSM to LOAD.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_last hold stable.
- Reset mid-operation: any state returns to LOAD with counters cleared. The partial block is discarded. Buffer contents are not reset and are not observable.

## Timing
- Outputs in reset: in_ready=0 while wb_rst_ni=0, then 1 on the first cycle after deassertion. out_valid=0, out_last=0, out_data=0, busy=0.
- Last sample accepted at edge t: COMPUTE occupies cycles t+1..t+N/2·LOGN. out_valid rises in cycle t+1+N/2·LOGN (for N=16, t+33).
- With out_ready held high, one coefficient transfers per cycle, so UNLOAD lasts N cycles.
- in_ready returns to 1 in the cycle after the out_last handshake.
- Throughput with no stalls: one block per N + N/2·LOGN + N cycles.
- busy and in_ready are mutually exclusive.

## Configuration
- WHT_SEQUENCY_ORDER_EN defined: UNLOAD emits coefficients in sequency (Walsh) order, with map(k) = bitrev_LOGN(k ^ (k>>1)).
- Not defined: map(k) = k, so coefficients come out in natural Hadamard order.
- Timing and latency are identical in both builds.

## Test plan
All scenarios use BW=8, LOGN=4.
- Impulse: x0=1, rest 0 → all 16 outputs = 1; out_last only on the 16th output.
- DC at minimum value: all samples −128 → first output −2048, remaining 15 outputs 0. This checks full-width sign handling.
- Alternating row, without macro: input +1,−1 repeating → output index 1 = 16, all others 0.
- Alternating row, with WHT_SEQUENCY_ORDER_EN: same input → output index 15 = 16, all others 0.
- Backpressure: out_ready toggles 1,0,0,1 with a random ramp input (0..15) → out_data holds during stalls and the sequence matches the golden model. in_valid held high during COMPUTE → no samples taken, in_ready=0 for exactly 32 cycles.
- Reset mid-COMPUTE: pulse wb_rst_ni low at cycle 10 of COMPUTE → outputs return to reset values immediately; a fresh impulse block afterwards produces all ones.
